// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between clients A and B,
// with a built-in sequencer that zeroes every word on command.
//
// state  | meaning
// IDLE   | sample clr_start / requests, latch the granted command
// ACCESS | RAM driven with latched command; read data captured at exit
// RESP   | ack pulse visible to the granted port
// CLEAR  | one zero-write per cycle, address 0 .. 2**ADDR_W-1
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr_start,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [1:0]        state_q, state_d;
  logic              ptr_b_q, ptr_b_d;
  logic              gnt_b_q, gnt_b_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              busy_q, busy_d;
  logic              ram_ena_q, ram_ena_d;
  logic              ram_wena_q, ram_wena_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              sel_b;

  // B wins when it is alone, or when both ask and the pointer names B.
  assign sel_b = req_b && (!req_a || ptr_b_q);

  always_comb begin
    state_d     = state_q;
    ptr_b_d     = ptr_b_q;
    gnt_b_d     = gnt_b_q;
    cnt_d       = cnt_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    busy_d      = busy_q;
    ram_ena_d   = ram_ena_q;
    ram_wena_d  = ram_wena_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      ST_IDLE: begin
        ram_ena_d  = 1'b0;
        ram_wena_d = 1'b0;
        if (clr_start) begin
          state_d     = ST_CLEAR;
          busy_d      = 1'b1;
          cnt_d       = '0;
          ram_ena_d   = 1'b1;
          ram_wena_d  = 1'b1;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
        end else if (req_a || req_b) begin
          state_d     = ST_ACCESS;
          gnt_b_d     = sel_b;
          ptr_b_d     = !sel_b;
          ram_ena_d   = 1'b1;
          ram_wena_d  = sel_b ? we_b : we_a;
          ram_addr_d  = sel_b ? addr_b : addr_a;
          ram_wdata_d = sel_b ? wdata_b : wdata_a;
        end
      end
      ST_ACCESS: begin
        // The RAM only drives ram_rdata for reads; never capture on a write.
        if (!ram_wena_q) begin
          if (gnt_b_q) rdata_b_d = ram_rdata;
          else         rdata_a_d = ram_rdata;
        end
        ram_ena_d  = 1'b0;
        ram_wena_d = 1'b0;
        ack_a_d    = !gnt_b_q;
        ack_b_d    = gnt_b_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt_q == ADDR_LAST) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          cnt_d      = '0;
          ram_ena_d  = 1'b0;
          ram_wena_d = 1'b0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          ram_addr_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_b_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      cnt_q       <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      busy_q      <= 1'b0;
      ram_ena_q   <= 1'b0;
      ram_wena_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_b_q     <= ptr_b_d;
      gnt_b_q     <= gnt_b_d;
      cnt_q       <= cnt_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      busy_q      <= busy_d;
      ram_ena_q   <= ram_ena_d;
      ram_wena_q  <= ram_wena_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign busy      = busy_q;
  assign ram_ena   = ram_ena_q;
  assign ram_wena  = ram_wena_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
